jump_input_conditioner: RTL and testbench

JUMP_INPUT_CONDITIONER -- requirements
Module: jump_input_conditioner

---
 rtl/jump_input_conditioner.sv | 196 +++++++++++++++++++
 tb/tb_jump_input_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_input_conditioner.sv
// jump_input_conditioner
//
// Turns a raw jump pushbutton and a raw pause switch into clean control
// signals for the CPU. A button press becomes exactly one jump request,
// which stays pending until the display reports that it has consumed a frame.
//
// Ports
//   clk         : 100 MHz system clock; the only clock
//   reset       : asynchronous active-low reset; release is synchronised to clk
//   button_raw  : asynchronous jump pushbutton
//   pause_raw   : asynchronous pause switch
//   frame_ack   : one-cycle pulse when the display has consumed a frame
//   jump_req    : high while a jump is pending (registered)
//   jump_word   : CPU register image {29'd0, jump_req x3} (registered)
//   pause_db    : debounced pause level (registered)
//   jump_count  : number of jumps delivered, modulo 256 (registered)
//
// Parameter
//   DEBOUNCE_CYCLES : consecutive cycles a new level must hold before it is
//                     accepted

module jump_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button_raw,
  input  logic        pause_raw,
  input  logic        frame_ack,
  output logic        jump_req,
  output logic [31:0] jump_word,
  output logic        pause_db,
  output logic [7:0]  jump_count
);

  // A one-cycle debounce still needs a one-bit counter so the vectors are legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One debounce step. Returns {next_stable, next_count}.
  // The counter only runs while the synchronised input disagrees with the
  // accepted level. It reaches CNT_TERM after DEBOUNCE_CYCLES-1 cycles of
  // disagreement, and the new level is taken on the next cycle of
  // disagreement. Any agreement before then clears the counter, so a shorter
  // glitch is forgotten.
  function automatic logic [CNT_W:0] db_step(
    input logic             sync_v,
    input logic             stable_v,
    input logic [CNT_W-1:0] cnt_v
  );
    logic             stable_n;
    logic [CNT_W-1:0] cnt_n;
    stable_n = stable_v;
    cnt_n    = {CNT_W{1'b0}};
    if (sync_v == stable_v) begin
      cnt_n = {CNT_W{1'b0}};
    end else if (cnt_v == CNT_TERM) begin
      stable_n = sync_v;
      cnt_n    = {CNT_W{1'b0}};
    end else begin
      cnt_n = cnt_v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return {stable_n, cnt_n};
  endfunction

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  logic             btn_meta_r, btn_sync_r, btn_stable_r, btn_stable_d_r;
  logic             pause_meta_r, pause_sync_r, pause_stable_r;
  logic [CNT_W-1:0] btn_cnt_r, pause_cnt_r;
  logic [CNT_W:0]   btn_step_s, pause_step_s;
  logic             btn_rise_s;
  state_t           state_r, state_next_s;
  logic             count_inc_s;
  logic             jump_req_r;
  logic [31:0]      jump_word_r;
  logic [7:0]       jump_count_r;

  // Reset synchroniser: assertion is immediate, release follows two clk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Two-flop synchronisers for both asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      btn_meta_r   <= 1'b0;
      btn_sync_r   <= 1'b0;
      pause_meta_r <= 1'b0;
      pause_sync_r <= 1'b0;
    end else begin
      btn_meta_r   <= button_raw;
      btn_sync_r   <= btn_meta_r;
      pause_meta_r <= pause_raw;
      pause_sync_r <= pause_meta_r;
    end
  end

  assign btn_step_s   = db_step(btn_sync_r, btn_stable_r, btn_cnt_r);
  assign pause_step_s = db_step(pause_sync_r, pause_stable_r, pause_cnt_r);

  // Independent debounce state for the button and the pause switch.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      btn_stable_r   <= 1'b0;
      btn_stable_d_r <= 1'b0;
      btn_cnt_r      <= {CNT_W{1'b0}};
      pause_stable_r <= 1'b0;
      pause_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      btn_stable_r   <= btn_step_s[CNT_W];
      btn_stable_d_r <= btn_stable_r;
      btn_cnt_r      <= btn_step_s[CNT_W-1:0];
      pause_stable_r <= pause_step_s[CNT_W];
      pause_cnt_r    <= pause_step_s[CNT_W-1:0];
    end
  end

  assign btn_rise_s = btn_stable_r & ~btn_stable_d_r;

  // FSM next state. Pause overrides everything. Once paused, no rise is seen
  // again until the button is released and pressed again.
  always_comb begin
    state_next_s = state_r;
    count_inc_s  = 1'b0;
    if (pause_stable_r) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // A frame_ack in the same cycle is not consumed here.
          if (btn_rise_s) begin
            state_next_s = PEND;
          end else begin
            state_next_s = IDLE;
          end
        end
        PEND: begin
          if (frame_ack) begin
            state_next_s = HOLD;
            count_inc_s  = 1'b1;
          end else begin
            state_next_s = PEND;
          end
        end
        HOLD: begin
          if (!btn_stable_r) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = HOLD;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State register and registered outputs; request outputs track entry to PEND.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= IDLE;
      jump_req_r   <= 1'b0;
      jump_word_r  <= 32'd0;
      jump_count_r <= 8'd0;
    end else begin
      state_r      <= state_next_s;
      jump_req_r   <= (state_next_s == PEND);
      jump_word_r  <= {29'd0, {3{state_next_s == PEND}}};
      if (count_inc_s) begin
        jump_count_r <= jump_count_r + 8'd1;
      end else begin
        jump_count_r <= jump_count_r;
      end
    end
  end

  assign jump_req   = jump_req_r;
  assign jump_word  = jump_word_r;
  assign pause_db   = pause_stable_r;
  assign jump_count = jump_count_r;

endmodule

// File: tb/tb_jump_input_conditioner.sv
// Testbench for jump_input_conditioner with DEBOUNCE_CYCLES = 4.
// Directed steps in one initial block. A negedge monitor pops expected
// jump_count values from a scoreboard queue whenever the count changes.

module tb_jump_input_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        button_raw = 1'b0;
  logic        pause_raw = 1'b0;
  logic        frame_ack = 1'b0;
  logic        jump_req;
  logic [31:0] jump_word;
  logic        pause_db;
  logic [7:0]  jump_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_count = 8'd0;
  logic [7:0]  prev_count = 8'd0;
  logic        prev_rst = 1'b0;

  jump_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .pause_raw  (pause_raw),
    .frame_ack  (frame_ack),
    .jump_req   (jump_req),
    .jump_word  (jump_word),
    .pause_db   (pause_db),
    .jump_count (jump_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press, wait (bounded) for the request, acknowledge, release.
  task automatic press_ack(input string tag);
    bit seen;
    seen = 1'b0;
    button_raw = 1'b1;
    for (int i = 0; i < 15 && !seen; i++) begin
      step(1);
      if (jump_req === 1'b1) seen = 1'b1;
    end
    check({tag, "_rise"}, {31'd0, seen}, 32'd1);
    exp_count = exp_count + 8'd1;
    exp_q.push_back(exp_count);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    button_raw = 1'b0;
    step(8);
  endtask

  // Scoreboard: every count change outside reset must match the next expected value.
  always @(negedge clk) begin
    if (reset && prev_rst && (jump_count !== prev_count)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_count", {24'd0, jump_count}, {24'd0, prev_count});
      end else begin
        check("count_seq", {24'd0, jump_count}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_count = jump_count;
    prev_rst   = reset;
  end

  initial begin
    bit seen;

    // Reset state
    reset = 1'b0;
    step(3);
    check("rst_req", {31'd0, jump_req}, 32'd0);
    check("rst_word", jump_word, 32'd0);
    check("rst_pause", {31'd0, pause_db}, 32'd0);
    check("rst_count", {24'd0, jump_count}, 32'd0);
    reset = 1'b1;
    step(5);

    // Held press: request appears 2+4+1 cycles after the edge and stays
    button_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("t1_req", {31'd0, jump_req}, (k >= 7) ? 32'd1 : 32'd0);
      if (k == 7) check("t1_word", jump_word, 32'h0000_0007);
    end

    // Ack consumes the request; a second ack while held is ignored
    exp_count = 8'd1;
    exp_q.push_back(8'd1);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    check("t2_req_fall", {31'd0, jump_req}, 32'd0);
    check("t2_count", {24'd0, jump_count}, 32'd1);
    check("t2_word", jump_word, 32'd0);
    step(3);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    step(2);
    check("t2_second_ack", {24'd0, jump_count}, 32'd1);
    check("t2_hold_req", {31'd0, jump_req}, 32'd0);
    button_raw = 1'b0;
    step(10);

    // A 3-cycle glitch is rejected
    button_raw = 1'b1;
    step(3);
    button_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      check("t3_req", {31'd0, jump_req}, 32'd0);
    end
    check("t3_count", {24'd0, jump_count}, 32'd1);

    // A 4-cycle press is accepted
    button_raw = 1'b1;
    step(4);
    button_raw = 1'b0;
    step(3);
    check("t3b_accept", {31'd0, jump_req}, 32'd1);
    exp_count = 8'd2;
    exp_q.push_back(8'd2);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    check("t3b_count", {24'd0, jump_count}, 32'd2);
    step(10);

    // Pause blocks presses
    pause_raw = 1'b1;
    step(10);
    check("t4_pause_db", {31'd0, pause_db}, 32'd1);
    button_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("t4_req_paused", {31'd0, jump_req}, 32'd0);
    end
    button_raw = 1'b0;
    step(10);
    pause_raw = 1'b0;
    step(10);
    check("t4_pause_off", {31'd0, pause_db}, 32'd0);

    // Pause raised during PEND drops the request within one cycle
    button_raw = 1'b1;
    step(8);
    check("t4_pend", {31'd0, jump_req}, 32'd1);
    pause_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1);
      if (pause_db === 1'b1) seen = 1'b1;
    end
    check("t4_pause_rise", {31'd0, seen}, 32'd1);
    step(1);
    check("t4_req_drop", {31'd0, jump_req}, 32'd0);
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    step(1);
    check("t4_count_paused", {24'd0, jump_count}, 32'd2);

    // Button still held as pause releases: no jump
    pause_raw = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      check("t4_held_release", {31'd0, jump_req}, 32'd0);
    end
    check("t4_pause_low", {31'd0, pause_db}, 32'd0);
    button_raw = 1'b0;
    step(10);

    // Reset asserted mid-PEND between edges clears outputs at once
    button_raw = 1'b1;
    step(8);
    check("t5_pend", {31'd0, jump_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_req", {31'd0, jump_req}, 32'd0);
    check("t5_count", {24'd0, jump_count}, 32'd0);
    check("t5_word", jump_word, 32'd0);
    exp_count = 8'd0;
    exp_q.delete();
    button_raw = 1'b0;
    step(2);
    reset = 1'b1;
    step(5);

    // 256 press/ack cycles wrap the count back to zero
    for (int n = 0; n < 256; n++) begin
      press_ack("t6");
    end
    step(2);
    check("t6_wrap", {24'd0, jump_count}, 32'd0);
    check("t6_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
